modulo_controle_jogada: RTL and testbench

Turn sequencer for the naval-battle board. It debounces the confirm and new-game buttons, validates the 6-bit attack coordinate, and checks it against the position (po) and attack (at) matrices. It drives the write-enable, index and clear strobes of the attack matrix register, and the 2-bit status code that the 7-segment multiplexer displays. It also tracks remaining shots and ship cells and flags game over.

---
 rtl/modulo_controle_jogada_pkg.sv | 27 ++
 rtl/modulo_controle_jogada_debounce.sv | 49 ++++
 rtl/modulo_controle_jogada.sv | 157 +++++++++++++++
 tb/tb_modulo_controle_jogada.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_controle_jogada_pkg.sv
// Shared states, status codes and board geometry for the naval-battle turn sequencer.
package pkg_batalha;

  typedef enum logic [2:0] {
    S_NEW,
    S_LOAD,
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_OVER
  } state_t;

  localparam logic [1:0] ST_ESPERA   = 2'b00;
  localparam logic [1:0] ST_AGUA     = 2'b01;
  localparam logic [1:0] ST_ACERTO   = 2'b10;
  localparam logic [1:0] ST_INVALIDO = 2'b11;

  localparam int ROWS  = 5;
  localparam int COLS  = 7;
  localparam int CELLS = 35;

  // Matrices are stored column-major with row 0 at the high end of each column.
  function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return 6'(col) * 6'd5 + (6'd4 - 6'(row));
  endfunction

endpackage

// File: rtl/modulo_controle_jogada_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and one-cycle rising-edge pulse.
module modulo_debounce_pulso #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam logic [19:0] CNT_LAST = 20'(DEB_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        level_q, level_d;
  logic [19:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;

  // Any cycle where the synchronized input agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/modulo_controle_jogada.sv
// Turn sequencer: validates the attack coordinate, drives the attack-matrix strobes,
// tracks shots and ship cells, and reports the status code and game result.
module modulo_controle_jogada
  import pkg_batalha::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int MAX_SHOTS  = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_confirm,
  input  logic        btn_new,
  input  logic [5:0]  coord_at,
  input  logic [34:0] m_po,
  input  logic [34:0] m_at,
  output logic        at_we,
  output logic [5:0]  at_idx,
  output logic        at_clr,
  output logic [1:0]  status,
  output logic [5:0]  shots_left,
  output logic [5:0]  hits_left,
  output logic        game_over,
  output logic        game_won
);

  localparam logic [5:0] SHOTS_INIT = 6'(MAX_SHOTS);

  logic cfm_p, new_p;

  modulo_debounce_pulso #(.DEB_CYCLES(DEB_CYCLES)) u_deb_confirm (
    .clk_i  (clk),
    .rst_ni (clr),
    .btn_i  (btn_confirm),
    .pulse_o(cfm_p)
  );

  modulo_debounce_pulso #(.DEB_CYCLES(DEB_CYCLES)) u_deb_new (
    .clk_i  (clk),
    .rst_ni (clr),
    .btn_i  (btn_new),
    .pulse_o(new_p)
  );

  state_t     state_q;
  logic       new_pend_q;
  logic [5:0] at_idx_q, shots_q, hits_q;
  logic [1:0] status_q;
  logic       over_q, won_q;

  logic [5:0] po_count;
  always_comb begin
    po_count = '0;
    for (int i = 0; i < CELLS; i++) begin
      po_count = po_count + {5'b0, m_po[i]};
    end
  end

  logic [2:0] row, col;
  logic       coord_bad, new_req, po_hit;
  logic [5:0] shots_dec, hits_next;

  assign row       = coord_at[5:3];
  assign col       = coord_at[2:0];
  assign coord_bad = (row >= 3'(ROWS)) || (col >= 3'(COLS));
  assign new_req   = new_pend_q | new_p;
  assign po_hit    = m_po[at_idx_q];
  assign shots_dec = (shots_q != 6'd0) ? shots_q - 6'd1 : 6'd0;
  assign hits_next = (po_hit && hits_q != 6'd0) ? hits_q - 6'd1 : hits_q;

  // A new-game request preempts every state except S_WRITE, which finishes its update first.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_NEW;
      new_pend_q <= 1'b0;
      at_idx_q   <= '0;
      shots_q    <= '0;
      hits_q     <= '0;
      status_q   <= ST_ESPERA;
      over_q     <= 1'b0;
      won_q      <= 1'b0;
    end else if (state_q != S_WRITE && new_req) begin
      state_q    <= S_NEW;
      new_pend_q <= 1'b0;
    end else begin
      new_pend_q <= new_req;
      case (state_q)
        S_NEW: begin
          shots_q  <= SHOTS_INIT;
          status_q <= ST_ESPERA;
          over_q   <= 1'b0;
          won_q    <= 1'b0;
          state_q  <= S_LOAD;
        end
        S_LOAD: begin
          hits_q <= po_count;
          if (po_count == 6'd0) begin
            over_q  <= 1'b1;
            won_q   <= 1'b1;
            state_q <= S_OVER;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (cfm_p) begin
            if (coord_bad) begin
              status_q <= ST_INVALIDO;
            end else begin
              at_idx_q <= cell_index(row, col);
              state_q  <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (m_at[at_idx_q]) begin
            status_q <= ST_INVALIDO;
            state_q  <= S_IDLE;
          end else begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          shots_q  <= shots_dec;
          hits_q   <= hits_next;
          status_q <= po_hit ? ST_ACERTO : ST_AGUA;
          if (new_req) begin
            new_pend_q <= 1'b0;
            state_q    <= S_NEW;
          end else if (hits_next == 6'd0) begin
            over_q  <= 1'b1;
            won_q   <= 1'b1;
            state_q <= S_OVER;
          end else if (shots_dec == 6'd0) begin
            over_q  <= 1'b1;
            won_q   <= 1'b0;
            state_q <= S_OVER;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_OVER: state_q <= S_OVER;
        default: state_q <= S_NEW;
      endcase
    end
  end

  // Strobes decode the registered state; at_clr is held low while reset is asserted.
  assign at_we      = (state_q == S_WRITE);
  assign at_clr     = (state_q == S_NEW) && clr;
  assign at_idx     = at_idx_q;
  assign status     = status_q;
  assign shots_left = shots_q;
  assign hits_left  = hits_q;
  assign game_over  = over_q;
  assign game_won   = won_q;

endmodule

// File: tb/tb_modulo_controle_jogada.sv
// Scoreboard bench for the turn sequencer: two instances (15 shots and 2 shots) with short debounce.
module tb_modulo_controle_jogada;

  localparam int DEB = 4;
  localparam int WIN = DEB + 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        btnCfm    [2];
  logic        btnNew    [2];
  logic [5:0]  coordAt   [2];
  logic [34:0] mPo       [2];
  logic [34:0] mAt       [2];
  logic        atWe      [2];
  logic [5:0]  atIdx     [2];
  logic        atClr     [2];
  logic [1:0]  status    [2];
  logic [5:0]  shotsLeft [2];
  logic [5:0]  hitsLeft  [2];
  logic        gameOver  [2];
  logic        gameWon   [2];

  modulo_controle_jogada #(.DEB_CYCLES(DEB), .MAX_SHOTS(15)) dut (
    .clk(clk), .clr(clr), .btn_confirm(btnCfm[0]), .btn_new(btnNew[0]),
    .coord_at(coordAt[0]), .m_po(mPo[0]), .m_at(mAt[0]),
    .at_we(atWe[0]), .at_idx(atIdx[0]), .at_clr(atClr[0]), .status(status[0]),
    .shots_left(shotsLeft[0]), .hits_left(hitsLeft[0]),
    .game_over(gameOver[0]), .game_won(gameWon[0])
  );

  modulo_controle_jogada #(.DEB_CYCLES(DEB), .MAX_SHOTS(2)) dut2 (
    .clk(clk), .clr(clr), .btn_confirm(btnCfm[1]), .btn_new(btnNew[1]),
    .coord_at(coordAt[1]), .m_po(mPo[1]), .m_at(mAt[1]),
    .at_we(atWe[1]), .at_idx(atIdx[1]), .at_clr(atClr[1]), .status(status[1]),
    .shots_left(shotsLeft[1]), .hits_left(hitsLeft[1]),
    .game_over(gameOver[1]), .game_won(gameWon[1])
  );

  typedef struct {
    int         weCount;
    int         clrCount;
    int         idx;
    int         stLat;
    logic [1:0] status;
    int         shots;
    int         hits;
    bit         over;
    bit         won;
  } exp_t;

  exp_t sbq[$];

  int         mShots   [2];
  int         mHits    [2];
  logic [1:0] mStatus  [2];
  bit         mOver    [2];
  bit         mWon     [2];
  int         maxShots [2] = '{15, 2};

  int passCount = 0;
  int checkCount = 0;

  function automatic int popc(input logic [34:0] v);
    int n = 0;
    for (int i = 0; i < 35; i++) n += int'(v[i]);
    return n;
  endfunction

  // Compare final counters/flags of unit u against the popped expectation.
  task automatic compare_state(input int u, input exp_t e, input string tag);
    checkCount++;
    if (status[u] !== e.status) $display("[TB] FAIL %s status: got %b want %b", tag, status[u], e.status);
    else passCount++;
    checkCount++;
    if (shotsLeft[u] !== 6'(e.shots)) $display("[TB] FAIL %s shots_left: got %0d want %0d", tag, shotsLeft[u], e.shots);
    else passCount++;
    checkCount++;
    if (hitsLeft[u] !== 6'(e.hits)) $display("[TB] FAIL %s hits_left: got %0d want %0d", tag, hitsLeft[u], e.hits);
    else passCount++;
    checkCount++;
    if (gameOver[u] !== e.over) $display("[TB] FAIL %s game_over: got %b want %b", tag, gameOver[u], e.over);
    else passCount++;
    checkCount++;
    if (gameWon[u] !== e.won) $display("[TB] FAIL %s game_won: got %b want %b", tag, gameWon[u], e.won);
    else passCount++;
  endtask

  task automatic fire(input int u, input int row, input int col, input string tag);
    exp_t       e;
    int         idx, weK, stK, weCount, seenIdx;
    logic [1:0] prevStatus;
    idx = 5 * col + (4 - row);
    prevStatus = mStatus[u];
    e.weCount = 0; e.clrCount = 0; e.idx = idx; e.stLat = 0;
    if (!mOver[u]) begin
      if (row > 4 || col > 6) begin
        mStatus[u] = 2'b11; e.stLat = DEB + 3;
      end else if (mAt[u][idx]) begin
        mStatus[u] = 2'b11; e.stLat = DEB + 4;
      end else begin
        e.weCount = 1; e.stLat = DEB + 5;
        mShots[u]--;
        if (mPo[u][idx]) begin mHits[u]--; mStatus[u] = 2'b10; end
        else mStatus[u] = 2'b01;
        if (mHits[u] == 0) begin mOver[u] = 1; mWon[u] = 1; end
        else if (mShots[u] == 0) begin mOver[u] = 1; mWon[u] = 0; end
      end
    end
    e.status = mStatus[u]; e.shots = mShots[u]; e.hits = mHits[u];
    e.over = mOver[u]; e.won = mWon[u];
    sbq.push_back(e);

    coordAt[u] = {3'(row), 3'(col)};
    btnCfm[u] = 1'b1;
    weK = 0; stK = 0; weCount = 0; seenIdx = -1;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clk); #1;
      if (atWe[u]) begin
        weCount++;
        if (weK == 0) begin weK = k; seenIdx = int'(atIdx[u]); end
      end
      if (stK == 0 && status[u] !== prevStatus) stK = k;
    end
    btnCfm[u] = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    #1;

    e = sbq.pop_front();
    if (e.weCount == 1) mAt[u][e.idx] = 1'b1;
    checkCount++;
    if (weCount !== e.weCount) $display("[TB] FAIL %s at_we_cycles: got %0d want %0d", tag, weCount, e.weCount);
    else passCount++;
    if (e.weCount == 1) begin
      checkCount++;
      if (seenIdx !== e.idx) $display("[TB] FAIL %s at_idx: got %0d want %0d", tag, seenIdx, e.idx);
      else passCount++;
      checkCount++;
      if (weK !== DEB + 4) $display("[TB] FAIL %s at_we_latency: got %0d want %0d", tag, weK, DEB + 4);
      else passCount++;
    end
    if (e.status !== prevStatus) begin
      checkCount++;
      if (stK !== e.stLat) $display("[TB] FAIL %s status_latency: got %0d want %0d", tag, stK, e.stLat);
      else passCount++;
    end
    compare_state(u, e, tag);
  endtask

  task automatic new_game_model(input int u, output exp_t e);
    mShots[u] = maxShots[u];
    mHits[u] = popc(mPo[u]);
    mStatus[u] = 2'b00;
    mOver[u] = (mHits[u] == 0);
    mWon[u] = (mHits[u] == 0);
    e.status = mStatus[u]; e.shots = mShots[u]; e.hits = mHits[u];
    e.over = mOver[u]; e.won = mWon[u];
  endtask

  task automatic test_new_game(input int u, input string tag);
    exp_t e;
    int   clrCount, clrK, weCount;
    new_game_model(u, e);
    e.weCount = 0; e.clrCount = 1; e.idx = 0; e.stLat = DEB + 3;
    sbq.push_back(e);
    btnNew[u] = 1'b1;
    clrCount = 0; clrK = 0; weCount = 0;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clk); #1;
      if (atClr[u]) begin clrCount++; if (clrK == 0) clrK = k; end
      if (atWe[u]) weCount++;
    end
    btnNew[u] = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    #1;
    mAt[u] = '0;
    e = sbq.pop_front();
    checkCount++;
    if (clrCount !== e.clrCount) $display("[TB] FAIL %s at_clr_cycles: got %0d want %0d", tag, clrCount, e.clrCount);
    else passCount++;
    checkCount++;
    if (clrK !== e.stLat) $display("[TB] FAIL %s at_clr_latency: got %0d want %0d", tag, clrK, e.stLat);
    else passCount++;
    checkCount++;
    if (weCount !== e.weCount) $display("[TB] FAIL %s at_we_cycles: got %0d want %0d", tag, weCount, e.weCount);
    else passCount++;
    compare_state(u, e, tag);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int u = 0; u < 2; u++) begin
      btnCfm[u] = 1'b0; btnNew[u] = 1'b0; coordAt[u] = '0; mAt[u] = '0;
    end
    mPo[0] = 35'h0_0000_0007;
    mPo[1] = 35'h0_0000_0001;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if ({atWe[0], atClr[0], gameOver[0], gameWon[0]} !== 4'b0000)
      $display("[TB] FAIL reset strobes_flags: got %b want 0000", {atWe[0], atClr[0], gameOver[0], gameWon[0]});
    else passCount++;
    checkCount++;
    if ({status[0], shotsLeft[0], hitsLeft[0]} !== 14'd0)
      $display("[TB] FAIL reset counters: got %0d/%0d/%0d want 0/0/0", status[0], shotsLeft[0], hitsLeft[0]);
    else passCount++;
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkCount++;
    if (atClr[0] !== 1'b1) $display("[TB] FAIL reset at_clr_in_new: got %b want 1", atClr[0]);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (atClr[0] !== 1'b0) $display("[TB] FAIL reset at_clr_width: got %b want 0", atClr[0]);
    else passCount++;
    checkCount++;
    if (shotsLeft[0] !== 6'd15) $display("[TB] FAIL reset shots_init: got %0d want 15", shotsLeft[0]);
    else passCount++;
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      exp_t e;
      new_game_model(u, e);
      compare_state(u, e, (u == 0) ? "reset_load" : "reset_load2");
    end
  endtask

  task automatic test_glitch();
    int weCount, clrCount;
    logic [1:0] st;
    st = mStatus[0];
    coordAt[0] = 6'b000_000;
    btnCfm[0] = 1'b1; btnNew[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btnCfm[0] = 1'b0; btnNew[0] = 1'b0;
    weCount = 0; clrCount = 0;
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk); #1;
      if (atWe[0]) weCount++;
      if (atClr[0]) clrCount++;
    end
    checkCount++;
    if (weCount !== 0) $display("[TB] FAIL glitch at_we_cycles: got %0d want 0", weCount);
    else passCount++;
    checkCount++;
    if (clrCount !== 0) $display("[TB] FAIL glitch at_clr_cycles: got %0d want 0", clrCount);
    else passCount++;
    checkCount++;
    if (status[0] !== st) $display("[TB] FAIL glitch status: got %b want %b", status[0], st);
    else passCount++;
  endtask

  // New-game press lands while the shot is in S_WRITE: write first, clear on the very next cycle.
  task automatic test_back_to_back();
    exp_t e;
    int   weK, clrK, weCount, clrCount;
    new_game_model(0, e);
    e.weCount = 1; e.clrCount = 1; e.idx = 0; e.stLat = DEB + 4;
    sbq.push_back(e);
    coordAt[0] = 6'b100_000;
    btnCfm[0] = 1'b1;
    weK = 0; clrK = 0; weCount = 0; clrCount = 0;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clk); #1;
      if (k == 2) btnNew[0] = 1'b1;
      if (atWe[0]) begin weCount++; if (weK == 0) weK = k; end
      if (atClr[0]) begin clrCount++; if (clrK == 0) clrK = k; end
    end
    btnCfm[0] = 1'b0; btnNew[0] = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    #1;
    mAt[0] = '0;
    e = sbq.pop_front();
    checkCount++;
    if (weCount !== e.weCount) $display("[TB] FAIL b2b at_we_cycles: got %0d want %0d", weCount, e.weCount);
    else passCount++;
    checkCount++;
    if (weK !== e.stLat) $display("[TB] FAIL b2b at_we_latency: got %0d want %0d", weK, e.stLat);
    else passCount++;
    checkCount++;
    if (clrK !== e.stLat + 1) $display("[TB] FAIL b2b at_clr_latency: got %0d want %0d", clrK, e.stLat + 1);
    else passCount++;
    checkCount++;
    if (clrCount !== e.clrCount) $display("[TB] FAIL b2b at_clr_cycles: got %0d want %0d", clrCount, e.clrCount);
    else passCount++;
    compare_state(0, e, "b2b");
  endtask

  task automatic test_miss();
    fire(0, 0, 6, "miss_r0c6");
  endtask

  task automatic test_invalid();
    fire(0, 5, 0, "invalid_row5");
    fire(0, 0, 7, "invalid_col7");
  endtask

  task automatic test_hit_repeat();
    fire(0, 4, 0, "hit_r4c0");
    fire(0, 4, 0, "repeat_r4c0");
  endtask

  task automatic test_win();
    fire(0, 3, 0, "hit_r3c0");
    fire(0, 2, 0, "win_r2c0");
    fire(0, 1, 0, "ignored_over");
  endtask

  task automatic test_shots_exhausted();
    fire(1, 0, 6, "s2_miss1");
    fire(1, 0, 5, "s2_lose");
    fire(1, 4, 0, "s2_ignored");
    test_new_game(1, "s2_new");
    fire(1, 0, 6, "s2_miss_again");
    fire(1, 4, 0, "s2_win_last_shot");
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_miss();
    test_invalid();
    test_hit_repeat();
    test_win();
    test_new_game(0, "new_game");
    test_glitch();
    test_back_to_back();
    test_shots_exhausted();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
